// File: rtl/inst_fetch_responder.sv
// Instruction-fetch responder: accepts one fetch at a time and returns the
// addressed word from an internal program-loaded array after LATENCY edges.
module inst_fetch_responder #(
  parameter int                 ADDR_W    = 64,
  parameter int                 DEPTH     = 1024,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter int                 LATENCY   = 2,
  localparam int                IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_inst,
  output logic              resp_err,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_idx,
  input  logic [31:0]       prog_data,
  output logic [31:0]       fetch_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [ADDR_W-1:0] LIMIT    = ADDR_W'(DEPTH * 4);
  // LATENCY=1 never enters WAIT, so the preload value is irrelevant there
  localparam logic [3:0]        CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t            r_state;
  state_t            w_nextState;
  logic [3:0]        r_cnt;
  logic [31:0]       r_inst;
  logic              r_err;
  logic [31:0]       r_fetchCnt;
  logic [31:0]       r_mem [DEPTH];

  logic [ADDR_W-1:0] w_off;
  logic [IDX_W-1:0]  w_idx;
  logic              w_err;
  logic              w_accept;
  logic              w_handshake;
  logic              w_reqReady;
  logic              w_respValid;

  // Addresses below BASE_ADDR wrap to a huge offset and fall into the error range
  assign w_off       = req_addr - BASE_ADDR;
  assign w_idx       = w_off[IDX_W+1:2];
  assign w_err       = (req_addr[1:0] != 2'b00) || (w_off >= LIMIT);
  assign w_accept    = req_valid && w_reqReady;
  assign w_handshake = w_respValid && resp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_nextState = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_reqReady  = 1'b0;
    w_respValid = 1'b0;
    case (r_state)
      IDLE:    w_reqReady  = 1'b1;
      RESP:    w_respValid = 1'b1;
      default: ;
    endcase
  end

  // The array read on the accepting edge sees the pre-write value of a same-edge program write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= 4'd0;
      r_inst     <= 32'h0;
      r_err      <= 1'b0;
      r_fetchCnt <= 32'h0;
    end else begin
      if (w_accept) begin
        r_inst <= w_err ? 32'h0 : r_mem[w_idx];
        r_err  <= w_err;
        r_cnt  <= CNT_INIT;
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_handshake) begin
        r_fetchCnt <= r_fetchCnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (prog_we) begin
      r_mem[prog_idx] <= prog_data;
    end
  end

  assign req_ready  = w_reqReady;
  assign resp_valid = w_respValid;
  assign resp_inst  = r_inst;
  assign resp_err   = r_err;
  assign fetch_cnt  = r_fetchCnt;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench: one LATENCY=2 responder for function checks, plus LATENCY=1
// and LATENCY=15 instances sharing a stimulus for latency and throughput.
module tb_inst_fetch_responder;

  logic        clock = 1'b0;
  logic        rst;

  logic        reqValid, reqReady, respValid, respReady, respErr;
  logic [63:0] reqAddr;
  logic [31:0] respInst, fetchCnt;

  logic        progWe;
  logic [9:0]  progIdx;
  logic [31:0] progData;

  logic        reqValidB, respReadyB;
  logic [63:0] reqAddrB;
  logic        reqReady1, respValid1, respErr1;
  logic [31:0] respInst1, fetchCnt1;
  logic        reqReady15, respValid15, respErr15;
  logic [31:0] respInst15, fetchCnt15;

  int passCount = 0;
  int totalCount = 0;

  always #5 clock = ~clock;

  inst_fetch_responder #(.LATENCY(2)) dut (
    .clk(clock), .rst(rst),
    .req_valid(reqValid), .req_ready(reqReady), .req_addr(reqAddr),
    .resp_valid(respValid), .resp_ready(respReady),
    .resp_inst(respInst), .resp_err(respErr),
    .prog_we(progWe), .prog_idx(progIdx), .prog_data(progData),
    .fetch_cnt(fetchCnt)
  );

  inst_fetch_responder #(.LATENCY(1)) dutLat1 (
    .clk(clock), .rst(rst),
    .req_valid(reqValidB), .req_ready(reqReady1), .req_addr(reqAddrB),
    .resp_valid(respValid1), .resp_ready(respReadyB),
    .resp_inst(respInst1), .resp_err(respErr1),
    .prog_we(progWe), .prog_idx(progIdx), .prog_data(progData),
    .fetch_cnt(fetchCnt1)
  );

  inst_fetch_responder #(.LATENCY(15)) dutLat15 (
    .clk(clock), .rst(rst),
    .req_valid(reqValidB), .req_ready(reqReady15), .req_addr(reqAddrB),
    .resp_valid(respValid15), .resp_ready(respReadyB),
    .resp_inst(respInst15), .resp_err(respErr15),
    .prog_we(progWe), .prog_idx(progIdx), .prog_data(progData),
    .fetch_cnt(fetchCnt15)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic progWrite(input logic [9:0] idx, input logic [31:0] data);
    progWe   = 1'b1;
    progIdx  = idx;
    progData = data;
    tick();
    progWe   = 1'b0;
  endtask

  // Presents one request, returns once resp_valid is seen (or the bound expires)
  task automatic applyStimulus(input logic [63:0] addr, output logic [31:0] inst,
                               output logic err, output int edges);
    reqValid = 1'b1;
    reqAddr  = addr;
    tick();
    reqValid = 1'b0;
    progWe   = 1'b0;
    edges    = 1;
    while (!respValid && edges < 40) begin
      tick();
      edges++;
    end
    inst = respInst;
    err  = respErr;
  endtask

  initial begin
    logic [31:0] inst;
    logic        err;
    int          edges;
    int          lat1, lat15;
    logic [31:0] base1, base15;

    rst        = 1'b0;
    reqValid   = 1'b0;
    reqAddr    = '0;
    respReady  = 1'b1;
    progWe     = 1'b0;
    progIdx    = '0;
    progData   = '0;
    reqValidB  = 1'b0;
    reqAddrB   = '0;
    respReadyB = 1'b1;

    #1;
    checkOutput("rst_req_ready", reqReady, 1);
    checkOutput("rst_resp_valid", respValid, 0);
    checkOutput("rst_resp_inst", respInst, 0);
    checkOutput("rst_resp_err", respErr, 0);
    checkOutput("rst_fetch_cnt", fetchCnt, 0);
    tick();
    tick();
    rst = 1'b1;

    progWrite(10'd0, 32'h0000_0513);
    progWrite(10'd1, 32'h0010_0093);
    progWrite(10'd2, 32'h0000_0013);

    // Basic fetches with resp_ready held high
    reqValid = 1'b1;
    reqAddr  = 64'h8000_0000;
    tick();
    reqValid = 1'b0;
    checkOutput("wait_req_ready", reqReady, 0);
    checkOutput("wait_resp_valid", respValid, 0);
    tick();
    checkOutput("f0_resp_valid_lat2", respValid, 1);
    checkOutput("f0_inst", respInst, 32'h0000_0513);
    checkOutput("f0_err", respErr, 0);
    tick();
    checkOutput("f0_back_idle", reqReady, 1);

    applyStimulus(64'h8000_0004, inst, err, edges);
    checkOutput("f1_latency", edges, 2);
    checkOutput("f1_inst", inst, 32'h0010_0093);
    checkOutput("f1_err", err, 0);
    tick();
    checkOutput("f1_fetch_cnt", fetchCnt, 2);

    // Error fetches: misaligned, past the array, below the base
    applyStimulus(64'h8000_0002, inst, err, edges);
    checkOutput("mis_err", err, 1);
    checkOutput("mis_inst", inst, 0);
    tick();
    applyStimulus(64'h8000_1000, inst, err, edges);
    checkOutput("oor_err", err, 1);
    checkOutput("oor_inst", inst, 0);
    tick();
    applyStimulus(64'h7FFF_FFFC, inst, err, edges);
    checkOutput("below_err", err, 1);
    tick();
    checkOutput("err_fetch_cnt", fetchCnt, 5);

    // Backpressure: response must hold while new requests and writes are ignored
    respReady = 1'b0;
    applyStimulus(64'h8000_0000, inst, err, edges);
    checkOutput("bp_inst", inst, 32'h0000_0513);
    reqValid = 1'b1;
    reqAddr  = 64'h8000_0004;
    progWrite(10'd0, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("bp_resp_valid", respValid, 1);
    checkOutput("bp_resp_inst", respInst, 32'h0000_0513);
    checkOutput("bp_req_ready", reqReady, 0);
    checkOutput("bp_fetch_cnt", fetchCnt, 5);
    reqValid  = 1'b0;
    respReady = 1'b1;
    tick();
    checkOutput("bp_release_valid", respValid, 0);
    checkOutput("bp_release_ready", reqReady, 1);
    checkOutput("bp_release_cnt", fetchCnt, 6);

    // Same-edge program write and accept: old word returned, new word afterwards
    progWe   = 1'b1;
    progIdx  = 10'd2;
    progData = 32'hDEAD_BEEF;
    applyStimulus(64'h8000_0008, inst, err, edges);
    checkOutput("rbw_old_word", inst, 32'h0000_0013);
    tick();
    applyStimulus(64'h8000_0008, inst, err, edges);
    checkOutput("rbw_new_word", inst, 32'hDEAD_BEEF);
    tick();
    checkOutput("rbw_fetch_cnt", fetchCnt, 8);

    // Asynchronous reset while a fetch is in WAIT
    reqValid = 1'b1;
    reqAddr  = 64'h8000_0004;
    tick();
    reqValid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_req_ready", reqReady, 1);
    checkOutput("arst_resp_valid", respValid, 0);
    checkOutput("arst_resp_inst", respInst, 0);
    checkOutput("arst_fetch_cnt", fetchCnt, 0);
    #2;
    rst = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("arst_dropped", respValid, 0);

    // LATENCY=1 and LATENCY=15 instances under continuous requests
    reqValidB = 1'b1;
    reqAddrB  = 64'h8000_0004;
    lat1  = 0;
    lat15 = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (lat1 == 0 && respValid1) lat1 = n;
      if (lat15 == 0 && respValid15) lat15 = n;
    end
    checkOutput("lat1_edges", lat1, 1);
    checkOutput("lat15_edges", lat15, 15);
    base1  = fetchCnt1;
    base15 = fetchCnt15;
    for (int n = 0; n < 32; n++) tick();
    checkOutput("lat1_throughput", fetchCnt1 - base1, 16);
    checkOutput("lat15_throughput", fetchCnt15 - base15, 2);
    reqValidB = 1'b0;

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
